rob_nway: RTL

Parametrised reorder buffer for the Tomasulo core: allocates in-order entries from the instruction queue and accepts out-of-order completions from `NUM_CDB` common data buses. It retires one instruction per cycle in program order, runs the d-cache handshake for loads and stores at the head, and flushes all younger work when a mispredicted branch retires. It sits between the instruction queue/reservation stations, the regfile and the d-cache.

---
 rtl/rob_nway.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rob_nway.sv
// Reorder buffer: in-order allocation, out-of-order CDB completion, in-order retire.
// Loads and stores handshake with the d-cache at the head; a mispredicted branch flushes.
module rob_nway #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NUM_CDB = 2,
  localparam int unsigned TAG_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [1:0]               alloc_type,
  input  logic [4:0]               alloc_rd,
  input  logic [4:0]               alloc_st_src,
  output logic                     alloc_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  output logic                     rf_allocate,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB-1:0]       cdb_mispredict,
  output logic                     commit_valid,
  output logic [TAG_W-1:0]         commit_tag,
  output logic [1:0]               commit_type,
  output logic [4:0]               commit_rd,
  output logic [4:0]               commit_st_src,
  output logic                     rf_load,
  output logic                     ld_commit_sel,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic                     mem_resp,
  output logic                     flush,
  output logic [TAG_W-1:0]         flush_tag,
  output logic [TAG_W:0]           count,
  output logic                     empty
);

  localparam logic [1:0] TypAlu = 2'd0;
  localparam logic [1:0] TypLd  = 2'd1;
  localparam logic [1:0] TypSt  = 2'd2;
  localparam logic [1:0] TypBr  = 2'd3;
  localparam logic [TAG_W:0] CountFull = (TAG_W + 1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, mispred_q, mispred_d;
  logic [1:0]       type_q   [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [4:0]       st_src_q [DEPTH];
  logic [TAG_W-1:0] head_q, tail_q;
  logic [TAG_W:0]   count_q, count_d;

  logic [TAG_W-1:0] cdb_tag_a [NUM_CDB];
  logic [1:0]       head_type;
  logic             head_ready, head_mem, full, alloc_fire;

  for (genvar g = 0; g < NUM_CDB; g++) begin : g_cdb
    assign cdb_tag_a[g] = cdb_tag[g*TAG_W +: TAG_W];
  end

  assign empty      = (count_q == '0);
  assign full       = (count_q == CountFull);
  assign head_type  = type_q[head_q];
  assign head_ready = !empty && done_q[head_q];
  assign head_mem   = (head_type == TypLd) || (head_type == TypSt);

  // Requests drop in the very cycle reset is sampled, not one cycle later.
  assign mem_read     = head_ready && (head_type == TypLd) && !rst;
  assign mem_write    = head_ready && (head_type == TypSt) && !rst;
  assign commit_valid = head_ready && (!head_mem || mem_resp);
  assign flush        = commit_valid && (head_type == TypBr) && mispred_q[head_q];

  assign alloc_ready = !full && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_q;
  assign rf_allocate = alloc_fire && ((alloc_type == TypAlu) || (alloc_type == TypLd));

  assign commit_tag    = head_q;
  assign commit_type   = head_type;
  assign commit_rd     = rd_q[head_q];
  assign commit_st_src = st_src_q[head_q];
  assign rf_load       = commit_valid && ((head_type == TypAlu) || (head_type == TypLd));
  assign ld_commit_sel = commit_valid && (head_type == TypLd);
  assign flush_tag     = head_q;
  assign count         = count_q;

  always_comb begin
    valid_d   = valid_q;
    done_d    = done_q;
    mispred_d = mispred_q;
    // Ports hitting the same tag accumulate since each reads the running _d value.
    for (int i = 0; i < NUM_CDB; i++) begin
      if (cdb_valid[i] && valid_q[cdb_tag_a[i]]) begin
        done_d[cdb_tag_a[i]]    = 1'b1;
        mispred_d[cdb_tag_a[i]] = mispred_d[cdb_tag_a[i]] | cdb_mispredict[i];
      end
    end
    if (commit_valid) valid_d[head_q] = 1'b0;
    if (alloc_fire) begin
      valid_d[tail_q]   = 1'b1;
      done_d[tail_q]    = 1'b0;
      mispred_d[tail_q] = 1'b0;
    end
    if (flush) begin
      valid_d   = '0;
      done_d    = '0;
      mispred_d = '0;
    end
  end

  always_comb begin
    count_d = count_q + (TAG_W + 1)'(alloc_fire) - (TAG_W + 1)'(commit_valid);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      mispred_q <= mispred_d;
      count_q   <= count_d;
      if (flush) begin
        head_q <= head_q + TAG_W'(1);
        tail_q <= head_q + TAG_W'(1);
      end else begin
        if (commit_valid) head_q <= head_q + TAG_W'(1);
        if (alloc_fire)   tail_q <= tail_q + TAG_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      type_q[tail_q]   <= alloc_type;
      rd_q[tail_q]     <= alloc_rd;
      st_src_q[tail_q] <= alloc_st_src;
    end
  end

endmodule
